// File: rtl/knn_feeder.sv
// knn_feeder: buffers CPU-written data points in a FIFO and streams them with the test point
// to the KNN core over its en/valid/ready handshake. Define KNN_FEEDER_REPLAY_EN for non-destructive replay.
module knn_feeder #(
  parameter int DATA_W    = 32,
  parameter int NBR_DATAP = 50,
  parameter int CNT_W     = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tp_wr,
  input  logic [DATA_W-1:0] i_tp_data,
  input  logic              i_dp_wr,
  input  logic [DATA_W-1:0] i_dp_data,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_nbr_points,
  input  logic              i_knn_stall,
  output logic              o_knn_en,
  output logic              o_knn_valid,
  output logic              o_knn_ready,
  output logic [DATA_W-1:0] o_knn_A,
  output logic [DATA_W-1:0] o_knn_B,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_fifo_level,
  output logic              o_overflow
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(NBR_DATAP);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO  = {CNT_W{1'b0}};

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [DATA_W-1:0] r_mem [NBR_DATAP];
  logic [CNT_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_level;
  logic [CNT_W-1:0]  r_remaining;
  logic [DATA_W-1:0] r_tp;
  logic              r_done;
  logic              r_overflow;

  logic              w_full;
  logic              w_avail;
  logic              w_valid;
  logic              w_xfer;
  logic              w_push;
  logic              w_start;
  logic              w_start_run;
  logic              w_last;
  logic              w_busy;
  logic [CNT_W-1:0]  w_nbr_clamped;

  // Pointers wrap at the FIFO depth, not at the counter width.
  function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
    return (p == DEPTH - ONE) ? ZERO : p + ONE;
  endfunction

  assign w_full = (r_level == DEPTH);

`ifdef KNN_FEEDER_REPLAY_EN
  logic [CNT_W-1:0] r_avail;
  assign w_avail = (r_avail != ZERO);
  assign w_push  = i_dp_wr & ~w_full;
`else
  assign w_avail = (r_level != ZERO);
  assign w_push  = i_dp_wr & (~w_full | w_xfer);
`endif

  assign w_busy        = (r_state == S_ARM) | (r_state == S_STREAM) | (r_state == S_WAIT);
  assign w_valid       = (r_state == S_STREAM) & w_avail;
  assign w_xfer        = w_valid & ~i_knn_stall;
  assign w_start       = i_start & (r_state == S_IDLE);
  assign w_start_run   = w_start & (i_nbr_points != ZERO);
  assign w_last        = w_xfer & (r_remaining == ONE);
  assign w_nbr_clamped = (i_nbr_points > DEPTH) ? DEPTH : i_nbr_points;

  // Next-state decode for the run sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_run) w_state_nxt = S_ARM;
        else             w_state_nxt = S_IDLE;
      end
      S_ARM:  w_state_nxt = S_STREAM;
      S_STREAM: begin
        if (w_last)        w_state_nxt = S_FINISH;
        else if (!w_avail) w_state_nxt = S_WAIT;
        else               w_state_nxt = S_STREAM;
      end
      S_WAIT: begin
        if (w_avail) w_state_nxt = S_STREAM;
        else         w_state_nxt = S_WAIT;
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dp_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= ZERO;
      r_rd_ptr <= ZERO;
      r_level  <= ZERO;
`ifdef KNN_FEEDER_REPLAY_EN
      r_avail  <= ZERO;
`endif
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
`ifdef KNN_FEEDER_REPLAY_EN
      // Stored data never moves, so the tail is always slot zero.
      if (w_start_run) r_rd_ptr <= ZERO;
      else if (w_xfer) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push) r_level <= r_level + ONE;
      if (w_start_run)          r_avail <= r_level + (w_push ? ONE : ZERO);
      else if (w_push & ~w_xfer) r_avail <= r_avail + ONE;
      else if (~w_push & w_xfer) r_avail <= r_avail - ONE;
`else
      if (w_xfer) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push & ~w_xfer)      r_level <= r_level + ONE;
      else if (~w_push & w_xfer) r_level <= r_level - ONE;
`endif
    end
  end

  // Run state, remaining count, status flags and test point.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_remaining <= ZERO;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_tp        <= {DATA_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_start_run) r_remaining <= w_nbr_clamped;
      else if (w_xfer) r_remaining <= r_remaining - ONE;
      // A zero-length start completes immediately.
      if (w_start_run)           r_done <= 1'b0;
      else if (w_start | w_last) r_done <= 1'b1;
      if (i_dp_wr & ~w_push) r_overflow <= 1'b1;
      else if (w_start)      r_overflow <= 1'b0;
      if (i_tp_wr & ~w_busy) r_tp <= i_tp_data;
    end
  end

  assign o_knn_en     = w_busy;
  assign o_busy       = w_busy;
  assign o_knn_valid  = w_valid;
  assign o_knn_ready  = w_xfer;
  assign o_knn_A      = r_tp;
  assign o_knn_B      = w_valid ? r_mem[r_rd_ptr] : {DATA_W{1'b0}};
  assign o_done       = r_done;
  assign o_fifo_level = r_level;
  assign o_overflow   = r_overflow;

endmodule

// File: doc/knn_feeder.md
Name: knn_feeder

Overview:
- Producer side of the KNN core streaming interface.
- Buffers data points written by the CPU register interface in an internal FIFO and holds one test point.
- On `start`, streams `NBR_DATAP`-bounded point pairs to the core using the core's `en`/`valid`/`ready` handshake.
- Reports completion and FIFO status back to the register file.

Parameters:
- DATA_W, 32, width of one packed point (x in [DATA_W-1:DATA_W/2], y in [DATA_W/2-1:0]).
- NBR_DATAP, 50, maximum data points per run; also the FIFO depth.
- CNT_W, 6, width of point counters; must satisfy 2^CNT_W > NBR_DATAP.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tp_wr  in  1  write-strobe, loads test point register
- tp_data  in  DATA_W  test point value
- dp_wr  in  1  write-strobe, pushes one data point into FIFO
- dp_data  in  DATA_W  data point value
- start  in  1  single-cycle run request
- nbr_points  in  CNT_W  number of points to stream this run (sampled on start)
- knn_stall  in  1  core backpressure; no transfer while high
- knn_en  out  1  core enable, high for the whole run
- knn_valid  out  1  one transfer per cycle when high and knn_stall low
- knn_ready  out  1  distance-compute strobe, equal to a transfer qualifier (valid & ~stall)
- knn_A  out  DATA_W  test point, constant during run
- knn_B  out  DATA_W  current data point (FIFO head)
- busy  out  1  run in progress
- done  out  1  sticky, set at end of run, cleared on start
- fifo_level  out  CNT_W  current FIFO occupancy
- overflow  out  1  sticky, dp_wr while FIFO full; cleared on start

Behaviour:
- Reset (rst low, async): all outputs 0; FIFO empty (pointers 0); state IDLE; `knn_A` = 0.
- `tp_wr` ignored while `busy`. `dp_wr` is accepted in any state if the FIFO is not full.
- `dp_wr` while full: data dropped, `overflow` set. A simultaneous push and pop on a full FIFO is accepted (level unchanged).
- FSM states: IDLE, ARM, STREAM, WAIT, FINISH.
- IDLE:
  - On `start` with `nbr_points` != 0: latch count (clamped to NBR_DATAP), clear `done`/`overflow`, go to ARM.
  - On `start` with `nbr_points` == 0: set `done` next cycle, stay IDLE.
  - `start` while not IDLE is ignored.
- ARM (1 cycle): `knn_en` = 1, `busy` = 1; gives the core one enable cycle before data. Go to STREAM.
- STREAM:
  - `knn_valid` = 1 when FIFO not empty; `knn_B` = FIFO head.
  - Transfer when `knn_valid` & ~`knn_stall`: pop FIFO, decrement remaining count, `knn_ready` high the same cycle.
  - FIFO empty with count remaining: go to WAIT with `knn_valid` = 0.
  - Last transfer: go to FINISH.
- WAIT: `knn_en` held 1, `knn_valid` 0; return to STREAM the cycle after the FIFO becomes non-empty.
- FINISH (1 cycle): `knn_en` 0, `busy` 0, `done` 1; go to IDLE.
- Latency: first `knn_valid` two cycles after the `start` edge when the FIFO is non-empty. Peak throughput is one point per clock.
- `knn_B` and `knn_valid` remain stable while `knn_stall` is high.
- `fifo_level` width arithmetic is modulo-free: pointers wrap at NBR_DATAP, not at 2^CNT_W.
- Reset mid-run: immediate return to IDLE, FIFO flushed, no further `knn_ready` pulses.

Optional Feature:
- KNN_FEEDER_REPLAY_EN:
  - Defined:
    - Reads are non-destructive. A separate read pointer is reset to the FIFO tail on each `start`, so the same data set streams against successive test points without rewriting.
    - `fifo_level` reports stored points.
    - A `dp_wr` during a run is still appended.
    - `nbr_points` greater than stored points stalls in WAIT until written.
  - Undefined: destructive pop as described above.

Test Plan:
- Reset, write tp = 0x0003_0004, push 3 points (0x0001_0001, 0x0002_0002, 0x0005_0005), start with nbr_points = 3 -> `knn_en` high from cycle +1, three consecutive `knn_valid`/`knn_ready` pulses carrying B in push order with A = 0x0003_0004, `done` = 1 one cycle after last, `fifo_level` = 0.
- Same run with `knn_stall` high for 4 cycles on the 2nd point -> B held at 0x0002_0002 for 4 cycles, exactly 3 `knn_ready` pulses total.
- Start with nbr_points = 5 and 2 points in FIFO, push 3 more 10 cycles later -> WAIT entered after 2 transfers, `knn_en` stays 1, remaining 3 transfer, `done` after 5.
- Push 51 points with NBR_DATAP = 50 -> `fifo_level` = 50, `overflow` = 1; next start clears `overflow`.
- Start with nbr_points = 0 -> no `knn_en`, `done` = 1 next cycle; assert rst low mid-STREAM -> all outputs 0 asynchronously, `fifo_level` = 0.
- With KNN_FEEDER_REPLAY_EN: push 4 points, run twice with different tp -> identical B sequences both runs, `fifo_level` = 4 afterwards.
